// File: rtl/ahb_lite_pkg.sv
// Shared AHB-Lite encodings, slave FSM states and the byte-lane helper.
package ahb_lite_pkg;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_BUSY   = 2'b01;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [1:0] HTRANS_SEQ    = 2'b11;

  localparam logic [2:0] HSIZE_BYTE  = 3'd0;
  localparam logic [2:0] HSIZE_HALF  = 3'd1;
  localparam logic [2:0] HSIZE_WORD  = 3'd2;
  localparam logic [2:0] HSIZE_DWORD = 3'd3;

  localparam logic HRESP_OKAY  = 1'b0;
  localparam logic HRESP_ERROR = 1'b1;

  typedef enum logic [1:0] {
    ST_OKAY = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR1 = 2'd2,
    ST_ERR2 = 2'd3
  } state_e;

  // Byte enables for a transfer of 2^hsize bytes starting at lane low_addr
  // (up to an 8-byte bus; narrower buses use the low bits).
  function automatic logic [7:0] lane_mask(input logic [2:0] hsize,
                                           input logic [2:0] low_addr);
    logic [7:0] m;
    case (hsize)
      HSIZE_BYTE:  m = 8'h01;
      HSIZE_HALF:  m = 8'h03;
      HSIZE_WORD:  m = 8'h0F;
      HSIZE_DWORD: m = 8'hFF;
      default:     m = 8'h00;
    endcase
    return m << low_addr;
  endfunction

endpackage

// File: rtl/ahb_lite_sram_array.sv
// Flop-array memory: byte-lane writes, asynchronous read, no reset.
module ahb_lite_sram_array #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 1024
) (
  input  logic                       clk,
  input  logic                       we,
  input  logic [DATA_WIDTH/8-1:0]    be,
  input  logic [$clog2(DEPTH)-1:0]   idx,
  input  logic [DATA_WIDTH-1:0]      wdata,
  output logic [DATA_WIDTH-1:0]      rdata
);

  localparam int BYTES = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];

  // Commit the enabled byte lanes of the addressed word.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (be[b]) mem_q[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[idx];

endmodule

// File: rtl/ahb_lite_sram_slave.sv
// AHB-Lite SRAM slave: address decode/error checks, wait-state FSM and
// the data-phase read/write path onto the flop array.
module ahb_lite_sram_slave
  import ahb_lite_pkg::*;
#(
  parameter int                    ADDR_WIDTH = 32,
  parameter int                    DATA_WIDTH = 32,
  parameter int                    DEPTH      = 1024,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
  parameter int                    NSEQ_WAIT  = 0,
  parameter int                    SEQ_WAIT   = 0
) (
  input  logic                  hclk,
  input  logic                  hresetn,
  input  logic                  hsel,
  input  logic [ADDR_WIDTH-1:0] haddr,
  input  logic [1:0]            htrans,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [2:0]            hburst,
  input  logic [3:0]            hprot,
  input  logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  output logic                  hreadyout,
  output logic                  hresp,
  output logic [DATA_WIDTH-1:0] hrdata
);

  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int LANE_W = $clog2(BYTES);
  localparam int IDX_W  = $clog2(DEPTH);
  localparam logic [ADDR_WIDTH:0] SPAN  = (ADDR_WIDTH+1)'(DEPTH * BYTES);
  localparam logic [ADDR_WIDTH:0] LIMIT = {1'b0, BASE_ADDR} + SPAN;

  state_e             state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               pend_q, pend_d;
  logic               write_q, write_d;
  logic               ready_q, ready_d;
  logic               resp_q, resp_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [BYTES-1:0]   be_q, be_d;

  logic               accept;
  logic               range_err, size_err, align_err, addr_err;
  logic [3:0]         load_cnt;
  logic [7:0]         lanes_all;
  logic               mem_we;
  logic               rd_done;
  logic [DATA_WIDTH-1:0] arr_rdata;
  logic               unused_sigs;

  // Only a ready slave (OKAY/ERR2) can take a new address phase.
  assign accept    = hsel && hready && htrans[1] && ready_q;
  assign range_err = ({1'b0, haddr} < {1'b0, BASE_ADDR}) || ({1'b0, haddr} >= LIMIT);
  assign size_err  = hsize > 3'(LANE_W);
  assign align_err = |(haddr[2:0] & ((3'b001 << hsize) - 3'b001));
  assign addr_err  = range_err || size_err || align_err;
  assign load_cnt  = (htrans == HTRANS_SEQ) ? 4'(SEQ_WAIT) : 4'(NSEQ_WAIT);
  assign lanes_all = lane_mask(hsize, 3'(haddr[LANE_W-1:0]));
  assign unused_sigs = ^{hburst, hprot, lanes_all};

  // Next-state logic: capture accepted transfers and sequence wait/error beats.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    write_d = write_q;
    idx_d   = idx_q;
    be_d    = be_q;
    unique case (state_q)
      ST_OKAY, ST_ERR2: begin
        state_d = ST_OKAY;
        pend_d  = 1'b0;
        if (accept) begin
          write_d = hwrite;
          idx_d   = haddr[LANE_W +: IDX_W];
          be_d    = lanes_all[BYTES-1:0];
          cnt_d   = load_cnt;
          if (addr_err) begin
            state_d = ST_ERR1;
          end else begin
            pend_d = 1'b1;
            if (load_cnt != 4'd0) state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = ST_OKAY;
      end
      ST_ERR1: state_d = ST_ERR2;
      default: state_d = ST_OKAY;
    endcase
    ready_d = (state_d == ST_OKAY) || (state_d == ST_ERR2);
    resp_d  = ((state_d == ST_ERR1) || (state_d == ST_ERR2)) ? HRESP_ERROR : HRESP_OKAY;
  end

  // Control state; reset abandons any pending transfer.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q <= ST_OKAY;
      cnt_q   <= 4'd0;
      pend_q  <= 1'b0;
      write_q <= 1'b0;
      ready_q <= 1'b1;
      resp_q  <= HRESP_OKAY;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      write_q <= write_d;
      ready_q <= ready_d;
      resp_q  <= resp_d;
    end
  end

  // Registered word index and byte lanes; qualified by pend_q, so no reset.
  always_ff @(posedge hclk) begin
    idx_q <= idx_d;
    be_q  <= be_d;
  end

  // The completing data-phase cycle is a pending transfer in OKAY.
  assign mem_we  = pend_q && write_q && (state_q == ST_OKAY);
  assign rd_done = pend_q && !write_q && (state_q == ST_OKAY);

  ahb_lite_sram_array #(
    .DATA_WIDTH(DATA_WIDTH),
    .DEPTH     (DEPTH)
  ) u_array (
    .clk  (hclk),
    .we   (mem_we),
    .be   (be_q),
    .idx  (idx_q),
    .wdata(hwdata),
    .rdata(arr_rdata)
  );

  assign hreadyout = ready_q;
  assign hresp     = resp_q;
  assign hrdata    = rd_done ? arr_rdata : '0;

endmodule
